// File: rtl/hamming_secded_codec_if.sv
// hamming_secded_codec_if: handshake, data and status bundle between a source/sink and the SECDED codec
interface hamming_secded_codec_if #(
    parameter int DATA_W = 4,
    parameter int CNT_W  = 8
);
    function automatic int calc_p(input int dw);
        int r = 7;
        for (int p = 7; p >= 1; p--) r = ((1 << p) >= dw + p + 1) ? p : r;
        return r;
    endfunction
    localparam int P      = calc_p(DATA_W);
    localparam int CODE_W = DATA_W + P + 1;
    logic              mode;
    logic              in_valid;
    logic              in_ready;
    logic [CODE_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [CODE_W-1:0] out_data;
    logic [1:0]        out_err;
    logic [P-1:0]      out_syn;
    logic              clr_cnt;
    logic [CNT_W-1:0]  corr_cnt;
    logic [CNT_W-1:0]  uncorr_cnt;
    modport slave (
        input  mode, in_valid, in_data, out_ready, clr_cnt,
        output in_ready, out_valid, out_data, out_err, out_syn, corr_cnt, uncorr_cnt
    );
    modport master (
        output mode, in_valid, in_data, out_ready, clr_cnt,
        input  in_ready, out_valid, out_data, out_err, out_syn, corr_cnt, uncorr_cnt
    );
endinterface

// File: rtl/hamming_secded_codec.sv
// hamming_secded_codec: streaming SECDED encoder/decoder with registered output and saturating error counters
module hamming_secded_codec #(
    parameter int DATA_W = 4,
    parameter int CNT_W  = 8
) (
    input logic                  clk,
    input logic                  rst_n,
    hamming_secded_codec_if.slave bus
);
    function automatic int calc_p(input int dw);
        int r = 7;
        for (int p = 7; p >= 1; p--) r = ((1 << p) >= dw + p + 1) ? p : r;
        return r;
    endfunction
    localparam int P      = calc_p(DATA_W);
    localparam int N      = DATA_W + P;
    localparam int CODE_W = N + 1;

    // Hamming position pos lives at code bit CODE_W-pos; data fills non-power-of-two positions MSB first
    function automatic logic [CODE_W-1:0] encode(input logic [DATA_W-1:0] d);
        logic [CODE_W-1:0] c = '0;
        logic [P-1:0]      s = '0;
        int                j = DATA_W - 1;
        for (int pos = 1; pos <= N; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                c |= CODE_W'(1'(d >> j)) << (CODE_W - pos);
                s ^= 1'(d >> j) ? P'(pos) : '0;
                j--;
            end
        end
        for (int k = 0; k < P; k++) c |= CODE_W'(1'(s >> k)) << (CODE_W - (1 << k));
        c[0] = ^c[CODE_W-1:1];
        return c;
    endfunction

    function automatic logic [P-1:0] syndrome(input logic [CODE_W-1:0] c);
        logic [P-1:0] s = '0;
        for (int pos = 1; pos <= N; pos++) s ^= 1'(c >> (CODE_W - pos)) ? P'(pos) : '0;
        return s;
    endfunction

    function automatic logic [DATA_W-1:0] extract(input logic [CODE_W-1:0] c);
        logic [DATA_W-1:0] d = '0;
        int                j = DATA_W - 1;
        for (int pos = 1; pos <= N; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                d |= DATA_W'(1'(c >> (CODE_W - pos))) << j;
                j--;
            end
        end
        return d;
    endfunction

    logic              out_valid_q, out_valid_d;
    logic [CODE_W-1:0] out_data_q, out_data_d;
    logic [1:0]        out_err_q, out_err_d;
    logic [P-1:0]      out_syn_q, out_syn_d;
    logic [CNT_W-1:0]  corr_q, corr_d, uncorr_q, uncorr_d;
    logic [CODE_W-1:0] enc, fixed;
    logic [P-1:0]      syn;
    logic              ovr, flip_ok, accept;
    logic [1:0]        dec_err, load_err;
    int                flip_sh;

    assign enc      = encode(bus.in_data[DATA_W-1:0]);
    assign syn      = syndrome(bus.in_data);
    assign ovr      = ^bus.in_data;
    assign flip_ok  = ovr && int'(syn) <= N;
    // syndrome 0 with odd parity means the overall parity bit itself flipped
    assign flip_sh  = (syn == '0) ? 0 : CODE_W - int'(syn);
    assign fixed    = bus.in_data ^ (flip_ok ? (CODE_W'(1) << flip_sh) : '0);
    assign dec_err  = flip_ok ? 2'b01 : ((ovr || syn != '0) ? 2'b10 : 2'b00);
    assign load_err = bus.mode ? dec_err : 2'b00;
    assign bus.in_ready = rst_n && (!out_valid_q || bus.out_ready);
    assign accept   = bus.in_valid && bus.in_ready;

    always_comb begin
        out_valid_d = accept || (out_valid_q && !bus.out_ready);
        out_data_d  = accept ? (bus.mode ? CODE_W'(extract(fixed)) : enc) : out_data_q;
        out_err_d   = accept ? load_err : out_err_q;
        out_syn_d   = accept ? (bus.mode ? syn : '0) : out_syn_q;
        corr_d      = bus.clr_cnt ? '0 : (accept && load_err == 2'b01 && corr_q != '1) ? corr_q + CNT_W'(1) : corr_q;
        uncorr_d    = bus.clr_cnt ? '0 : (accept && load_err == 2'b10 && uncorr_q != '1) ? uncorr_q + CNT_W'(1) : uncorr_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_err_q   <= '0;
            out_syn_q   <= '0;
            corr_q      <= '0;
            uncorr_q    <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_err_q   <= out_err_d;
            out_syn_q   <= out_syn_d;
            corr_q      <= corr_d;
            uncorr_q    <= uncorr_d;
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = out_data_q;
    assign bus.out_err    = out_err_q;
    assign bus.out_syn    = out_syn_q;
    assign bus.corr_cnt   = corr_q;
    assign bus.uncorr_cnt = uncorr_q;
endmodule

// File: tb/tb_hamming_secded_codec.sv
// tb_hamming_secded_codec: directed and randomized checks of the SECDED codec against a positional Hamming model
module tb_hamming_secded_codec;
    logic clk = 0;
    logic rst_n = 0;
    int   checks = 0;
    int   errors = 0;
    int   c_corr = 0;
    int   c_unc = 0;

    always #5 clk = ~clk;

    hamming_secded_codec_if #(.DATA_W(4), .CNT_W(2)) b4 ();
    hamming_secded_codec_if #(.DATA_W(11), .CNT_W(8)) b11 ();

    hamming_secded_codec #(.DATA_W(4), .CNT_W(2)) dut4 (.clk(clk), .rst_n(rst_n), .bus(b4));
    hamming_secded_codec #(.DATA_W(11), .CNT_W(8)) dut11 (.clk(clk), .rst_n(rst_n), .bus(b11));

    function automatic int np(input int dw);
        int p = 1;
        while ((1 << p) < dw + p + 1) p++;
        return p;
    endfunction

    function automatic bit is_pow2(input int x);
        return (x & (x - 1)) == 0;
    endfunction

    function automatic logic [15:0] m_enc(input int dw, input logic [15:0] d);
        int n = dw + np(dw);
        int di = dw - 1;
        logic [15:0] bp = '0;
        logic [15:0] c = '0;
        logic x;
        for (int pos = 1; pos <= n; pos++)
            if (!is_pow2(pos)) begin bp[pos] = d[di]; di--; end
        for (int k = 0; (1 << k) <= n; k++) begin
            x = 0;
            for (int pos = 1; pos <= n; pos++)
                if (!is_pow2(pos) && ((pos >> k) & 1) == 1) x ^= bp[pos];
            bp[1 << k] = x;
        end
        for (int pos = 1; pos <= n; pos++) c[n + 1 - pos] = bp[pos];
        c[0] = ^c;
        return c;
    endfunction

    function automatic logic [15:0] m_extract(input int dw, input logic [15:0] c);
        int n = dw + np(dw);
        int di = dw - 1;
        logic [15:0] r = '0;
        for (int pos = 1; pos <= n; pos++)
            if (!is_pow2(pos)) begin r[di] = c[n + 1 - pos]; di--; end
        return r;
    endfunction

    function automatic int m_pos(input int dw, input int i);
        return (i == 0) ? 0 : dw + np(dw) + 1 - i;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // called at a negedge; one accepted word, result checked at the following negedge
    task automatic do4(input string tag, input logic m, input logic [7:0] din, input logic clr,
                       input logic [7:0] ed, input logic [1:0] ee, input logic [2:0] es);
        b4.mode = m; b4.in_data = din; b4.in_valid = 1; b4.out_ready = 1; b4.clr_cnt = clr;
        #1 chk({tag, ".in_ready"}, 32'(b4.in_ready), 1);
        @(posedge clk); #1;
        b4.in_valid = 0; b4.clr_cnt = 0;
        if (clr) begin c_corr = 0; c_unc = 0; end
        else begin
            if (ee == 2'b01 && c_corr < 3) c_corr++;
            if (ee == 2'b10 && c_unc < 3) c_unc++;
        end
        @(negedge clk);
        chk({tag, ".valid"}, 32'(b4.out_valid), 1);
        chk({tag, ".data"}, 32'(b4.out_data), 32'(ed));
        chk({tag, ".err"}, 32'(b4.out_err), 32'(ee));
        chk({tag, ".syn"}, 32'(b4.out_syn), 32'(es));
        chk({tag, ".corr"}, 32'(b4.corr_cnt), c_corr);
        chk({tag, ".uncorr"}, 32'(b4.uncorr_cnt), c_unc);
    endtask

    task automatic do11(input string tag, input logic m, input logic [15:0] din,
                        input logic [15:0] ed, input logic [1:0] ee, input logic [3:0] es);
        b11.mode = m; b11.in_data = din; b11.in_valid = 1; b11.out_ready = 1;
        @(posedge clk); #1;
        b11.in_valid = 0;
        @(negedge clk);
        chk({tag, ".valid"}, 32'(b11.out_valid), 1);
        chk({tag, ".data"}, 32'(b11.out_data), 32'(ed));
        chk({tag, ".err"}, 32'(b11.out_err), 32'(ee));
        chk({tag, ".syn"}, 32'(b11.out_syn), 32'(es));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] d, c, cc;
        logic [7:0] bd[6];
        logic bm[6];
        int n, i, j;
        b4.mode = 0; b4.in_valid = 0; b4.in_data = '0; b4.out_ready = 1; b4.clr_cnt = 0;
        b11.mode = 0; b11.in_valid = 0; b11.in_data = '0; b11.out_ready = 1; b11.clr_cnt = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst.in_ready4", 32'(b4.in_ready), 0);
        chk("rst.in_ready11", 32'(b11.in_ready), 0);
        chk("rst.valid4", 32'(b4.out_valid), 0);
        chk("rst.corr4", 32'(b4.corr_cnt), 0);
        chk("rst.valid11", 32'(b11.out_valid), 0);
        rst_n = 1;

        do4("enc_B", 0, 8'h0B, 0, 8'h66, 2'b00, 3'd0);
        do4("dec_66", 1, 8'h66, 0, 8'h0B, 2'b00, 3'd0);
        do4("dec_46", 1, 8'h46, 0, 8'h0B, 2'b01, 3'd3);
        do4("dec_67", 1, 8'h67, 0, 8'h0B, 2'b01, 3'd0);
        do4("dec_56", 1, 8'h56, 0, 8'h03, 2'b10, 3'd7);

        do4("clr_idle", 0, 8'h00, 1, 8'h00, 2'b00, 3'd0);
        for (int k = 0; k < 5; k++) do4("sat", 1, 8'h46, 0, 8'h0B, 2'b01, 3'd3);
        do4("clr_prio", 1, 8'h46, 1, 8'h0B, 2'b01, 3'd3);

        for (int k = 0; k < 12; k++) begin
            d = 16'($urandom_range(0, 15));
            c = m_enc(4, d);
            do4("rnd4_enc", 0, 8'(d), 0, 8'(c), 2'b00, 3'd0);
            n = $urandom_range(0, 2);
            i = $urandom_range(0, 7);
            j = (i + 1 + $urandom_range(0, 6)) % 8;
            if (n == 0) do4("rnd4_clean", 1, 8'(c), 0, 8'(d), 2'b00, 3'd0);
            else if (n == 1) do4("rnd4_single", 1, 8'(c ^ (16'd1 << i)), 0, 8'(d), 2'b01, 3'(m_pos(4, i)));
            else begin
                cc = c ^ (16'd1 << i) ^ (16'd1 << j);
                do4("rnd4_double", 1, 8'(cc), 0, 8'(m_extract(4, cc)), 2'b10, 3'(m_pos(4, i) ^ m_pos(4, j)));
            end
        end
        do4("pre_bp", 1, 8'h46, 0, 8'h0B, 2'b01, 3'd3);

        b4.mode = 0; b4.in_data = 8'h0B; b4.in_valid = 1; b4.out_ready = 1;
        @(posedge clk); #1;
        b4.out_ready = 0; b4.mode = 0; b4.in_data = 8'h05;
        repeat (3) begin
            @(negedge clk);
            chk("bp.in_ready", 32'(b4.in_ready), 0);
            chk("bp.valid", 32'(b4.out_valid), 1);
            chk("bp.data", 32'(b4.out_data), 32'h66);
            chk("bp.err", 32'(b4.out_err), 0);
        end
        b4.out_ready = 1;
        for (int k = 0; k < 6; k++) begin
            d = (k == 0) ? 16'h5 : 16'($urandom_range(0, 15));
            bm[k] = (k % 2 == 1);
            bd[k] = bm[k] ? 8'(d) : 8'(m_enc(4, d));
            b4.mode = bm[k]; b4.in_data = bm[k] ? 8'(m_enc(4, d)) : 8'(d);
            @(posedge clk); #1;
            @(negedge clk);
            chk("stream.valid", 32'(b4.out_valid), 1);
            chk("stream.data", 32'(b4.out_data), 32'(bd[k]));
        end
        b4.in_valid = 0;
        @(negedge clk);
        chk("stream.drain", 32'(b4.out_valid), 0);

        b4.mode = 0; b4.in_data = 8'h05; b4.in_valid = 1; b4.out_ready = 0;
        @(posedge clk); #1;
        b4.in_valid = 0;
        @(negedge clk);
        chk("prerst.valid", 32'(b4.out_valid), 1);
        rst_n = 0;
        #1 chk("inrst.in_ready", 32'(b4.in_ready), 0);
        @(negedge clk);
        chk("rst2.valid", 32'(b4.out_valid), 0);
        chk("rst2.data", 32'(b4.out_data), 0);
        chk("rst2.err", 32'(b4.out_err), 0);
        chk("rst2.syn", 32'(b4.out_syn), 0);
        chk("rst2.corr", 32'(b4.corr_cnt), 0);
        chk("rst2.uncorr", 32'(b4.uncorr_cnt), 0);
        rst_n = 1; c_corr = 0; c_unc = 0;
        b4.out_ready = 1;

        for (int k = 0; k < 10; k++) begin
            d = 16'($urandom_range(0, 2047));
            c = m_enc(11, d);
            do11("rnd11_enc", 0, d, c, 2'b00, 4'd0);
            i = $urandom_range(0, 15);
            do11("rnd11_single", 1, c ^ (16'd1 << i), d, 2'b01, 4'(m_pos(11, i)));
        end
        d = 16'h5A5;
        do11("rnd11_clean", 1, m_enc(11, d), d, 2'b00, 4'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
